mem_ctrl: RTL and testbench

Single-port memory controller between the instruction-fetch unit, the load/store buffer and the byte-wide unified RAM/IO bus. It arbitrates the two requesters and serialises each 1/2/4-byte access into byte cycles on the 8-bit bus. It assembles little-endian read data and returns a one-cycle success pulse to the requester that was granted. It also applies the IO write back-pressure and the branch-mispredict abort for fetches.

---
 rtl/mem_ctrl_pkg.sv | 38 +++
 rtl/mem_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared configuration for the byte-serial memory controller: state encoding, access sizes,
// load/store tag and IO region decode.
package mem_ctrl_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned BusW  = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [2:0] SizeByte = 3'b001;
    localparam logic [2:0] SizeHalf = 3'b010;
    localparam logic [2:0] SizeWord = 3'b100;

    localparam logic TagLoad  = 1'b0;
    localparam logic TagStore = 1'b1;

    localparam logic [1:0] IoRegion = 2'b11;

    function automatic logic is_io(input logic [AddrW-1:0] addr);
        return addr[17:16] == IoRegion;
    endfunction

    // Unknown size codes fall back to a single byte so the byte counter always terminates.
    function automatic logic [2:0] size_bytes(input logic [2:0] size);
        case (size)
            SizeHalf: return 3'd2;
            SizeWord: return 3'd4;
            default:  return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetch and load/store requests onto a byte-wide RAM/IO bus,
// serialising each access into byte cycles and assembling little-endian read data.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             jump_flag,
    input  logic             if_enable,
    input  logic [AddrW-1:0] if_addr,
    output logic             if_success,
    output logic [DataW-1:0] if_data,
    input  logic             lsb_enable,
    input  logic [2:0]       lsb_size,
    input  logic [AddrW-1:0] lsb_addr,
    input  logic [DataW-1:0] lsb_wdata,
    input  logic             lsb_wr_tag,
    output logic             lsb_success,
    output logic [DataW-1:0] lsb_rdata,
    input  logic [BusW-1:0]  mem_din,
    output logic [BusW-1:0]  mem_dout,
    output logic [AddrW-1:0] mem_a,
    output logic             mem_wr,
    input  logic             io_buffer_full
);

    state_e           r_state, w_state;
    logic [2:0]       r_k, w_k;
    logic [2:0]       r_n, w_n;
    logic [AddrW-1:0] r_addr, w_addr;
    logic [DataW-1:0] r_wdata, w_wdata;
    logic             r_is_fetch, w_is_fetch;
    logic [DataW-1:0] r_data, w_data;
    logic             r_pend, w_pend;
    logic [1:0]       r_lane, w_lane;
    logic [AddrW-1:0] r_mem_a, w_mem_a;
    logic [BusW-1:0]  r_mem_dout, w_mem_dout;
    logic             r_mem_wr, w_mem_wr;
    logic             r_if_success, w_if_success;
    logic [DataW-1:0] r_if_data, w_if_data;
    logic             r_lsb_success, w_lsb_success;
    logic [DataW-1:0] r_lsb_rdata, w_lsb_rdata;

    logic [2:0]       w_next_k;
    logic [AddrW-1:0] w_next_a;
    logic [DataW-1:0] w_captured;

    assign w_next_k = r_k + 3'd1;
    assign w_next_a = r_addr + {29'd0, w_next_k};

    // r_pend marks a read address on the bus last cycle, so mem_din now belongs to lane r_lane.
    // Capture is not gated by rdy: a held address keeps re-delivering the same byte.
    always_comb begin
        w_captured = r_data;
        if (r_pend) begin
            w_captured[{r_lane, 3'b000} +: 8] = mem_din;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_k           = r_k;
        w_n           = r_n;
        w_addr        = r_addr;
        w_wdata       = r_wdata;
        w_is_fetch    = r_is_fetch;
        w_data        = w_captured;
        w_pend        = (r_state == StRead) && (r_k < r_n);
        w_lane        = r_k[1:0];
        w_mem_a       = r_mem_a;
        w_mem_dout    = r_mem_dout;
        w_mem_wr      = r_mem_wr;
        w_if_success  = 1'b0;
        w_if_data     = r_if_data;
        w_lsb_success = 1'b0;
        w_lsb_rdata   = r_lsb_rdata;

        if (rdy) begin
            unique case (r_state)
                StIdle: begin
                    if (lsb_enable) begin
                        w_is_fetch = 1'b0;
                        w_n        = size_bytes(lsb_size);
                        w_addr     = lsb_addr;
                        w_wdata    = lsb_wdata;
                        w_k        = 3'd0;
                        w_data     = '0;
                        w_mem_a    = lsb_addr;
                        if (lsb_wr_tag == TagLoad) begin
                            w_state = StRead;
                        end else begin
                            w_state    = StWrite;
                            w_mem_dout = lsb_wdata[7:0];
                            w_mem_wr   = !(is_io(lsb_addr) && io_buffer_full);
                        end
                    end else if (if_enable && !jump_flag) begin
                        w_is_fetch = 1'b1;
                        w_n        = 3'd4;
                        w_addr     = if_addr;
                        w_k        = 3'd0;
                        w_data     = '0;
                        w_mem_a    = if_addr;
                        w_state    = StRead;
                    end
                end
                StRead: begin
                    if (r_is_fetch && jump_flag) begin
                        w_state = StIdle;
                        w_k     = 3'd0;
                        w_pend  = 1'b0;
                        w_mem_a = '0;
                    end else if (r_k == r_n) begin
                        w_state = StDone;
                        w_k     = 3'd0;
                        if (r_is_fetch) begin
                            w_if_success = 1'b1;
                            w_if_data    = w_captured;
                        end else begin
                            w_lsb_success = 1'b1;
                            w_lsb_rdata   = w_captured;
                        end
                    end else begin
                        w_k     = w_next_k;
                        w_mem_a = (w_next_k < r_n) ? w_next_a : '0;
                    end
                end
                StWrite: begin
                    if (r_mem_wr) begin
                        if (w_next_k == r_n) begin
                            w_state       = StDone;
                            w_k           = 3'd0;
                            w_lsb_success = 1'b1;
                            w_mem_a       = '0;
                            w_mem_dout    = '0;
                            w_mem_wr      = 1'b0;
                        end else begin
                            w_k        = w_next_k;
                            w_mem_a    = w_next_a;
                            w_mem_dout = r_wdata[{w_next_k[1:0], 3'b000} +: 8];
                            w_mem_wr   = !(is_io(w_next_a) && io_buffer_full);
                        end
                    end else begin
                        // IO back-pressure: retry the same byte once the FIFO has room.
                        w_mem_wr = !(is_io(r_mem_a) && io_buffer_full);
                    end
                end
                StDone: begin
                    w_state = StIdle;
                end
                default: begin
                    w_state = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_k           <= '0;
            r_n           <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_is_fetch    <= 1'b0;
            r_data        <= '0;
            r_pend        <= 1'b0;
            r_lane        <= '0;
            r_mem_a       <= '0;
            r_mem_dout    <= '0;
            r_mem_wr      <= 1'b0;
            r_if_success  <= 1'b0;
            r_if_data     <= '0;
            r_lsb_success <= 1'b0;
            r_lsb_rdata   <= '0;
        end else begin
            r_state       <= w_state;
            r_k           <= w_k;
            r_n           <= w_n;
            r_addr        <= w_addr;
            r_wdata       <= w_wdata;
            r_is_fetch    <= w_is_fetch;
            r_data        <= w_data;
            r_pend        <= w_pend;
            r_lane        <= w_lane;
            r_mem_a       <= w_mem_a;
            r_mem_dout    <= w_mem_dout;
            r_mem_wr      <= w_mem_wr;
            r_if_success  <= w_if_success;
            r_if_data     <= w_if_data;
            r_lsb_success <= w_lsb_success;
            r_lsb_rdata   <= w_lsb_rdata;
        end
    end

    assign mem_a       = r_mem_a;
    assign mem_dout    = r_mem_dout;
    assign mem_wr      = r_mem_wr & rdy;
    assign if_success  = r_if_success;
    assign if_data     = r_if_data;
    assign lsb_success = r_lsb_success;
    assign lsb_rdata   = r_lsb_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized traffic against
// a byte-array reference model of memory contents and access latencies.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, jump_flag;
    logic        if_enable, if_success;
    logic [31:0] if_addr, if_data;
    logic        lsb_enable, lsb_wr_tag, lsb_success;
    logic [2:0]  lsb_size;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .jump_flag      (jump_flag),
        .if_enable      (if_enable),
        .if_addr        (if_addr),
        .if_success     (if_success),
        .if_data        (if_data),
        .lsb_enable     (lsb_enable),
        .lsb_size       (lsb_size),
        .lsb_addr       (lsb_addr),
        .lsb_wdata      (lsb_wdata),
        .lsb_wr_tag     (lsb_wr_tag),
        .lsb_success    (lsb_success),
        .lsb_rdata      (lsb_rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    // Bus-side RAM: read byte valid the cycle after its address.
    logic [7:0]  ram   [0:65535];
    logic [7:0]  model [0:65535];
    logic [39:0] wq[$];
    int          n_checks = 0;
    int          n_errs   = 0;

    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
        mem_din <= ram[mem_a[15:0]];
    end

    always @(negedge clk) begin
        if (mem_wr) wq.push_back({mem_a, mem_dout});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [2:0] size);
        return (size == SizeWord) ? 4 : (size == SizeHalf) ? 2 : 1;
    endfunction

    // One complete access from request to the cycle after its success pulse.
    task automatic txn(input bit fetch, input bit store, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                       input int rdy_at, input int rdy_len, input int jump_at);
        int          n, lat, exp_lat;
        logic [31:0] exp_data;
        bit          got;
        n        = fetch ? 4 : nbytes(size);
        exp_lat  = (store ? n + 1 : n + 2) + stall + rdy_len;
        exp_data = '0;
        if (!store) begin
            for (int k = 0; k < n; k++) exp_data[8*k +: 8] = model[16'(addr + 32'(k))];
        end
        wq.delete();
        if (fetch) begin
            if_addr   = addr;
            if_enable = 1'b1;
        end else begin
            lsb_addr   = addr;
            lsb_size   = size;
            lsb_wdata  = wdata;
            lsb_wr_tag = store ? TagStore : TagLoad;
            lsb_enable = 1'b1;
        end
        io_buffer_full = (stall > 0);
        got = 1'b0;
        lat = 0;
        while (!got && lat < 60) begin
            tick();
            lat++;
            got = fetch ? if_success : lsb_success;
            if (!store && rdy_len == 0 && lat <= n) begin
                check_eq("rd_addr", mem_a, addr + 32'(lat - 1));
            end
            if (lat == stall) io_buffer_full = 1'b0;
            if (rdy_len > 0 && lat == rdy_at) rdy = 1'b0;
            if (rdy_len > 0 && lat == rdy_at + rdy_len) rdy = 1'b1;
            jump_flag = (lat == jump_at);
        end
        check_eq(store ? "wr_latency" : "rd_latency", 32'(lat), 32'(exp_lat));
        if (!store) check_eq("rd_data", fetch ? if_data : lsb_rdata, exp_data);
        if_enable      = 1'b0;
        lsb_enable     = 1'b0;
        io_buffer_full = 1'b0;
        rdy            = 1'b1;
        jump_flag      = 1'b0;
        tick();
        check_eq("pulse_width", {30'd0, if_success, lsb_success}, 32'd0);
        if (store) begin
            check_eq("wr_count", 32'(wq.size()), 32'(n));
            for (int k = 0; k < n && k < wq.size(); k++) begin
                check_eq("wr_addr", wq[k][39:8], addr + 32'(k));
                check_eq("wr_byte", {24'd0, wq[k][7:0]}, {24'd0, wdata[8*k +: 8]});
            end
            for (int k = 0; k < n; k++) model[16'(addr + 32'(k))] = wdata[8*k +: 8];
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {29'd0, if_success, lsb_success, mem_wr}, 32'd0);
        check_eq(tag, mem_a, 32'd0);
        check_eq(tag, {24'd0, mem_dout}, 32'd0);
        check_eq(tag, if_data, 32'd0);
        check_eq(tag, lsb_rdata, 32'd0);
    endtask

    initial begin
        int lat, cnt, sel, stall;
        logic [2:0]  sz;
        logic [31:0] a, d;
        for (int i = 0; i < 65536; i++) begin
            ram[i]   = 8'($urandom);
            model[i] = ram[i];
        end
        ram[16'h100] = 8'h13; ram[16'h101] = 8'h05; ram[16'h102] = 8'h00; ram[16'h103] = 8'h00;
        ram[16'h202] = 8'h34; ram[16'h203] = 8'hFF;
        for (int i = 16'h100; i < 16'h104; i++) model[i] = ram[i];
        for (int i = 16'h202; i < 16'h204; i++) model[i] = ram[i];

        rst = 1'b1; rdy = 1'b1; jump_flag = 1'b0; io_buffer_full = 1'b0;
        if_enable = 1'b0; if_addr = '0;
        lsb_enable = 1'b0; lsb_size = SizeByte; lsb_addr = '0; lsb_wdata = '0; lsb_wr_tag = 1'b0;
        repeat (3) tick();
        check_all_zero("reset_state");
        rst = 1'b0;
        tick();

        txn(1'b1, 1'b0, SizeWord, 32'h100, '0, 0, 0, 0, 0);
        check_eq("fetch_word", if_data, 32'h0000_0513);
        txn(1'b0, 1'b0, SizeHalf, 32'h202, '0, 0, 0, 0, 0);
        check_eq("lh_data", lsb_rdata, 32'h0000_FF34);
        txn(1'b0, 1'b1, SizeWord, 32'h300, 32'hDEADBEEF, 0, 0, 0, 0);
        txn(1'b0, 1'b0, SizeWord, 32'h300, '0, 0, 0, 0, 0);
        check_eq("sw_readback", lsb_rdata, 32'hDEADBEEF);

        // Simultaneous requests: LSB first, fetch right after the cool-down cycle.
        lsb_addr = 32'h202; lsb_size = SizeByte; lsb_wr_tag = TagLoad; lsb_enable = 1'b1;
        if_addr = 32'h100; if_enable = 1'b1;
        lat = 0;
        do begin tick(); lat++; end while (!lsb_success && lat < 40);
        check_eq("arb_lsb_lat", 32'(lat), 32'd3);
        check_eq("arb_lsb_data", lsb_rdata, 32'h0000_0034);
        lsb_enable = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (!if_success && lat < 40);
        check_eq("arb_if_gap", 32'(lat), 32'd7);
        check_eq("arb_if_data", if_data, 32'h0000_0513);
        if_enable = 1'b0;
        tick();

        // Mispredict in c3 of a fetch.
        if_addr = 32'h100; if_enable = 1'b1;
        repeat (3) tick();
        jump_flag = 1'b1; if_enable = 1'b0;
        tick();
        check_eq("jmp_mem_a", mem_a, 32'd0);
        jump_flag = 1'b0;
        cnt = 0;
        repeat (8) begin if (if_success) cnt++; tick(); end
        check_eq("jmp_no_success", 32'(cnt), 32'd0);

        txn(1'b0, 1'b1, SizeWord, 32'h400, 32'h1234_5678, 0, 0, 0, 2);
        txn(1'b0, 1'b1, SizeByte, 32'h30000, 32'h0000_00A5, 3, 0, 0, 0);
        txn(1'b0, 1'b1, SizeWord, 32'h500, 32'hCAFE_F00D, 0, 2, 2, 0);
        txn(1'b1, 1'b0, SizeWord, 32'h500, '0, 0, 2, 2, 0);
        check_eq("rdy_fetch", if_data, 32'hCAFE_F00D);

        // Reset in the middle of a word fetch.
        if_addr = 32'h100; if_enable = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_all_zero("rst_mid");
        rst = 1'b0; if_enable = 1'b0;
        cnt = 0;
        repeat (8) begin if (if_success || lsb_success) cnt++; tick(); end
        check_eq("rst_no_success", 32'(cnt), 32'd0);
        txn(1'b1, 1'b0, SizeWord, 32'h100, '0, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            sel   = $urandom_range(0, 2);
            sz    = (sel == 0) ? SizeWord : 3'(1 << $urandom_range(0, 2));
            a     = 32'($urandom_range(0, 32'h7FF0));
            d     = $urandom;
            stall = 0;
            if (sel == 2 && $urandom_range(0, 3) == 0) begin
                a     = 32'h30000 | 32'($urandom_range(0, 255));
                sz    = SizeByte;
                stall = $urandom_range(1, 3);
            end
            txn(sel == 0, sel == 2, sz, a, d, stall, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
